// File: rtl/shared_timer_arbiter.sv
// Round-robin arbiter sharing one down-counting delay timer among NREQ requesters.
// Optional build macro SHARED_TIMER_FIXED_PRIO_EN selects fixed lowest-index priority instead.
module shared_timer_arbiter #(
  parameter int NREQ = 4,
  parameter int SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SIZE-1:0] len,
  input  logic                 hold,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic [SIZE-1:0]      count
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [SIZE-1:0]   count_q, count_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;

  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  cand;
  logic [SIZE-1:0]   pick_len;
  logic [NREQ-1:0]   pick_onehot;

  // Winner search; later loop iterations overwrite earlier ones, so the
  // loops run from least to most preferred candidate.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
`ifdef SHARED_TIMER_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(i);
      end
    end
`else
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr_q) + k) % NREQ);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
`endif
  end

`ifdef SHARED_TIMER_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^{ptr_q, cand};
`endif

  assign pick_len    = len[pick_idx*SIZE +: SIZE];
  assign pick_onehot = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    count_d = count_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = RUN;
          owner_d = pick_idx;
          grant_d = pick_onehot;
          count_d = pick_len;
        end
      end
      RUN: begin
        // Owner dropping its request kills the job silently.
        if (!req[owner_q]) begin
          state_d = IDLE;
          grant_d = '0;
          count_d = '0;
          ptr_d   = owner_q;
        end else if (hold) begin
          count_d = count_q;
        end else if (count_q == '0) begin
          state_d = DONE;
          done_d  = grant_q;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = owner_q;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      count_q <= '0;
      ptr_q   <= IDX_W'(NREQ - 1);
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign count = count_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_shared_timer_arbiter.sv
// Self-checking bench for shared_timer_arbiter: vector table, directed corner
// sequences and a randomized run against a job-level reference model.
module tb_shared_timer_arbiter;

  localparam int NREQ = 4;
  localparam int SIZE = 8;

  logic            clk;
  logic            rst;
  logic [3:0]      req;
  logic [31:0]     len;
  logic            hold;
  logic [3:0]      grant;
  logic [3:0]      done;
  logic            busy;
  logic [7:0]      count;

  int checks   = 0;
  int failures = 0;

  shared_timer_arbiter #(.NREQ(NREQ), .SIZE(SIZE)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .len  (len),
    .hold (hold),
    .grant(grant),
    .done (done),
    .busy (busy),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] len;
    logic        hold;
    logic [3:0]  g;
    logic [3:0]  d;
    logic        b;
    logic [7:0]  c;
  } vec_t;

  vec_t vecs[13];

  // Reference model: tracks the current job as owner / remaining count.
  int  m_owner = -1;
  bit  m_finishing = 0;
  int  m_cnt = 0;
  int  m_ptr = NREQ - 1;

  function automatic int lane_len(input logic [31:0] l, input int i);
    return int'((l >> (SIZE * i)) & 32'hFF);
  endfunction

  task automatic model_step();
    int order[$];
    if (rst) begin
      m_owner = -1; m_finishing = 0; m_cnt = 0; m_ptr = NREQ - 1;
    end else if (m_owner < 0) begin
`ifdef SHARED_TIMER_FIXED_PRIO_EN
      for (int i = 0; i < NREQ; i++) order.push_back(i);
`else
      for (int k = 1; k <= NREQ; k++) order.push_back((m_ptr + k) % NREQ);
`endif
      foreach (order[j]) begin
        if (m_owner < 0 && req[order[j]]) begin
          m_owner = order[j];
          m_cnt   = lane_len(len, order[j]);
        end
      end
    end else if (m_finishing) begin
      m_ptr = m_owner; m_owner = -1; m_finishing = 0;
    end else if (!req[m_owner]) begin
      m_ptr = m_owner; m_owner = -1; m_cnt = 0;
    end else if (!hold) begin
      if (m_cnt == 0) m_finishing = 1;
      else m_cnt = m_cnt - 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] q, input logic [31:0] l, input logic h);
    rst = r; req = q; len = l; hold = h;
    tick();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 600) begin
      tick();
      n++;
    end
    checkOutput(name, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic [3:0] exp_rr[5];
    logic [3:0] prev;
    logic [3:0] exp_next;
    int rises, last, n;

    rst = 1'b1; req = '0; len = '0; hold = 1'b0;

    vecs[0]  = '{1'b1, 4'b1111, 32'h5, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 4'b1111, 32'h5, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 4'b1111, 32'h5, 1'b0, 4'b0001, 4'b0000, 1'b1, 8'd5};
    vecs[3]  = '{1'b0, 4'b0001, 32'h5, 1'b0, 4'b0001, 4'b0000, 1'b1, 8'd4};
    vecs[4]  = '{1'b0, 4'b0001, 32'h5, 1'b0, 4'b0001, 4'b0000, 1'b1, 8'd3};
    vecs[5]  = '{1'b0, 4'b0001, 32'h5, 1'b0, 4'b0001, 4'b0000, 1'b1, 8'd2};
    vecs[6]  = '{1'b0, 4'b0001, 32'h5, 1'b0, 4'b0001, 4'b0000, 1'b1, 8'd1};
    vecs[7]  = '{1'b0, 4'b0001, 32'h5, 1'b0, 4'b0001, 4'b0000, 1'b1, 8'd0};
    vecs[8]  = '{1'b0, 4'b0001, 32'h5, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'd0};
    vecs[9]  = '{1'b0, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'd0};
    vecs[10] = '{1'b0, 4'b0100, 32'h0, 1'b0, 4'b0100, 4'b0000, 1'b1, 8'd0};
    vecs[11] = '{1'b0, 4'b0100, 32'h0, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'd0};
    vecs[12] = '{1'b0, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'd0};

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].len, vecs[i].hold);
      checkOutput($sformatf("vec%0d_grant", i), {28'b0, grant}, {28'b0, vecs[i].g});
      checkOutput($sformatf("vec%0d_done", i),  {28'b0, done},  {28'b0, vecs[i].d});
      checkOutput($sformatf("vec%0d_busy", i),  {31'b0, busy},  {31'b0, vecs[i].b});
      checkOutput($sformatf("vec%0d_count", i), {24'b0, count}, {24'b0, vecs[i].c});
    end

    // Back-to-back requesters: grant order and period len+3.
`ifdef SHARED_TIMER_FIXED_PRIO_EN
    exp_rr = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    applyStimulus(1'b1, 4'b0000, 32'h0, 1'b0);
    rst = 1'b0; req = 4'b1111; len = 32'h02020202;
    prev = '0; rises = 0; last = 0;
    for (int cyc = 0; cyc < 40 && rises < 5; cyc++) begin
      tick();
      if (grant != 4'b0 && prev == 4'b0) begin
        checkOutput($sformatf("rr_grant%0d", rises), {28'b0, grant}, {28'b0, exp_rr[rises]});
        if (rises > 0) checkOutput("rr_period", cyc - last, 32'd5);
        last = cyc;
        rises++;
      end
      prev = grant;
    end
    checkOutput("rr_rises", rises, 32'd5);
    req = 4'b0000;
    wait_idle("rr_idle");

    // Hold for 4 cycles mid-RUN delays done by 4 cycles.
    applyStimulus(1'b1, 4'b0000, 32'h0, 1'b0);
    applyStimulus(1'b0, 4'b0100, 32'h00030000, 1'b0);
    checkOutput("hold_grant", {28'b0, grant}, 32'b0100);
    checkOutput("hold_load", {24'b0, count}, 32'd3);
    tick();
    checkOutput("hold_dec", {24'b0, count}, 32'd2);
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("hold_freeze", {24'b0, count}, 32'd2);
      checkOutput("hold_nodone", {28'b0, done}, 32'd0);
    end
    hold = 1'b0;
    n = 5;
    while (done == 4'b0 && n < 30) begin
      tick();
      n++;
    end
    checkOutput("hold_latency", n, 32'd8);
    checkOutput("hold_done", {28'b0, done}, 32'b0100);
    req = 4'b0000;
    wait_idle("hold_idle");

    // Owner drops its request: silent abort, then round-robin moves on.
    applyStimulus(1'b1, 4'b0000, 32'h0, 1'b0);
    applyStimulus(1'b0, 4'b0010, 32'h00000500, 1'b0);
    checkOutput("abort_grant", {28'b0, grant}, 32'b0010);
    tick();
    tick();
    checkOutput("abort_count3", {24'b0, count}, 32'd3);
    req = 4'b0101;
    tick();
    checkOutput("abort_grant0", {28'b0, grant}, 32'd0);
    checkOutput("abort_busy0", {31'b0, busy}, 32'd0);
    checkOutput("abort_count0", {24'b0, count}, 32'd0);
    checkOutput("abort_nodone", {28'b0, done}, 32'd0);
    tick();
`ifdef SHARED_TIMER_FIXED_PRIO_EN
    exp_next = 4'b0001;
`else
    exp_next = 4'b0100;
`endif
    checkOutput("abort_next", {28'b0, grant}, {28'b0, exp_next});
    req = 4'b0000;
    wait_idle("abort_idle");

`ifdef SHARED_TIMER_FIXED_PRIO_EN
    applyStimulus(1'b1, 4'b0000, 32'h0, 1'b0);
    rst = 1'b0; req = 4'b1010; len = 32'h01010101;
    prev = '0; rises = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      if (grant != 4'b0 && prev == 4'b0) begin
        checkOutput("fixed_grant", {28'b0, grant}, 32'b0010);
        rises++;
      end
      prev = grant;
    end
    checkOutput("fixed_rises", (rises >= 3) ? 32'd1 : 32'd0, 32'd1);
    req = 4'b0000;
    wait_idle("fixed_idle");
`endif

    // Full-range length: no overflow, done len+1 cycles after grant.
    applyStimulus(1'b1, 4'b0000, 32'h0, 1'b0);
    applyStimulus(1'b0, 4'b1000, 32'hFF000000, 1'b0);
    checkOutput("full_load", {24'b0, count}, 32'd255);
    checkOutput("full_grant", {28'b0, grant}, 32'b1000);
    n = 0;
    while (done == 4'b0 && n < 300) begin
      tick();
      n++;
    end
    checkOutput("full_latency", n, 32'd256);
    req = 4'b0000;
    wait_idle("full_idle");

    // Reset mid-RUN kills the job without a done pulse.
    applyStimulus(1'b0, 4'b0001, 32'h0000000A, 1'b0);
    tick();
    tick();
    applyStimulus(1'b1, 4'b0001, 32'h0000000A, 1'b0);
    checkOutput("rstrun_grant", {28'b0, grant}, 32'd0);
    checkOutput("rstrun_busy", {31'b0, busy}, 32'd0);
    checkOutput("rstrun_count", {24'b0, count}, 32'd0);
    checkOutput("rstrun_done", {28'b0, done}, 32'd0);
    applyStimulus(1'b0, 4'b0000, 32'h0, 1'b0);
    checkOutput("rstrun_nodone", {28'b0, done}, 32'd0);

    // Randomized run against the reference model.
    applyStimulus(1'b1, 4'b0000, 32'h0, 1'b0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [31:0] l;
      rst  = ($urandom_range(0, 99) == 0);
      req  = req ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      hold = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NREQ; i++)
        l[i*SIZE +: SIZE] = ($urandom_range(0, 19) == 0) ? 8'hFF : 8'($urandom_range(0, 5));
      len = l;
      tick();
      checkOutput("rand_grant", {28'b0, grant},
                  (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      checkOutput("rand_done", {28'b0, done},
                  (m_owner >= 0 && m_finishing) ? (32'd1 << m_owner) : 32'd0);
      checkOutput("rand_busy", {31'b0, busy}, (m_owner >= 0) ? 32'd1 : 32'd0);
      checkOutput("rand_count", {24'b0, count}, m_cnt);
      checkOutput("rand_onehot", $onehot0(grant) ? 32'd1 : 32'd0, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
